// File: rtl/result_drain_pkg.sv
// Shared types and geometry helpers for the result tile drain engine.
package result_drain_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } rd_state_t;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Row-major stores one line per row; col-major stores one line per column.
   function automatic int lines_per_tile(input int rows, input int cols, input logic cm);
      return cm ? cols : rows;
   endfunction

   function automatic int line_len(input int rows, input int cols, input logic cm);
      return cm ? rows : cols;
   endfunction

   function automatic int chunks_per_line(input int rows, input int cols, input int lanes,
                                          input logic cm);
      return ceil_div(line_len(rows, cols, cm), lanes);
   endfunction

endpackage

// File: rtl/result_drain_addr_gen.sv
// Line/chunk counters and running write address for the drain engine.
import result_drain_pkg::*;

module result_drain_addr_gen #(
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int AWIDTH = 16,
   parameter int LANES  = 1,
   parameter int CW     = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_adv,
   input  logic              i_col_major,
   input  logic [AWIDTH-1:0] i_base,
   input  logic [AWIDTH-1:0] i_stride,
   output logic [AWIDTH-1:0] o_addr,
   output logic [CW-1:0]     o_l_nxt,
   output logic [CW-1:0]     o_k_nxt,
   output logic              o_last
);

   localparam int NL_RM = lines_per_tile(ROWS, COLS, 1'b0);
   localparam int NL_CM = lines_per_tile(ROWS, COLS, 1'b1);
   localparam int NK_RM = chunks_per_line(ROWS, COLS, LANES, 1'b0);
   localparam int NK_CM = chunks_per_line(ROWS, COLS, LANES, 1'b1);

   logic [CW-1:0]     r_l, r_k, w_l_nxt, w_k_nxt, w_nl_m1, w_nk_m1;
   logic [AWIDTH-1:0] r_line, r_addr, r_stride, w_line_nxt, w_addr_nxt, w_stride_nxt;

   assign w_nl_m1 = i_col_major ? CW'(NL_CM - 1) : CW'(NL_RM - 1);
   assign w_nk_m1 = i_col_major ? CW'(NK_CM - 1) : CW'(NK_RM - 1);
   assign o_last  = (r_l == w_nl_m1) && (r_k == w_nk_m1);

   // r_line tracks base + L*stride so no multiplier is needed.
   always_comb begin
      w_l_nxt      = r_l;
      w_k_nxt      = r_k;
      w_line_nxt   = r_line;
      w_addr_nxt   = r_addr;
      w_stride_nxt = r_stride;
      if (i_load) begin
         w_l_nxt      = '0;
         w_k_nxt      = '0;
         w_line_nxt   = i_base;
         w_addr_nxt   = i_base;
         w_stride_nxt = i_stride;
      end else if (i_adv) begin
         if (o_last) begin
            w_l_nxt      = '0;
            w_k_nxt      = '0;
            w_line_nxt   = '0;
            w_addr_nxt   = '0;
            w_stride_nxt = '0;
         end else if (r_k == w_nk_m1) begin
            w_k_nxt    = '0;
            w_l_nxt    = r_l + CW'(1);
            w_line_nxt = r_line + r_stride;
            w_addr_nxt = r_line + r_stride;
         end else begin
            w_k_nxt    = r_k + CW'(1);
            w_addr_nxt = r_addr + AWIDTH'(LANES);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_l      <= '0;
         r_k      <= '0;
         r_line   <= '0;
         r_addr   <= '0;
         r_stride <= '0;
      end else begin
         r_l      <= w_l_nxt;
         r_k      <= w_k_nxt;
         r_line   <= w_line_nxt;
         r_addr   <= w_addr_nxt;
         r_stride <= w_stride_nxt;
      end
   end

   assign o_addr  = r_addr;
   assign o_l_nxt = w_l_nxt;
   assign o_k_nxt = w_k_nxt;

endmodule

// File: rtl/result_drain.sv
// Streams a captured systolic result tile out as addressed, strobed write beats.
//   state | meaning
//   IDLE  | waiting for result_valid; captures tile and addressing on it
//   SEND  | presenting beats, advancing on wr_valid && wr_ready
import result_drain_pkg::*;

module result_drain #(
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 16,
   parameter int LANES  = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [ROWS*COLS*DWIDTH-1:0] result,
   input  logic                        result_valid,
   input  logic [AWIDTH-1:0]           base_addr,
   input  logic [AWIDTH-1:0]           row_stride,
   input  logic                        col_major,
   output logic                        wr_valid,
   input  logic                        wr_ready,
   output logic [AWIDTH-1:0]           wr_addr,
   output logic [LANES*DWIDTH-1:0]     wr_data,
   output logic [LANES-1:0]            wr_strb,
   output logic                        busy,
   output logic                        done,
   output logic                        overrun
);

   localparam int NE   = ROWS * COLS;
   localparam int TW   = NE * DWIDTH;
   localparam int LW   = LANES * DWIDTH;
   localparam int MAXD = max_int(ROWS, COLS);
   localparam int CW   = $clog2(MAXD + 1);

   rd_state_t         r_state, w_state_nxt;
   logic [TW-1:0]     r_tile, w_tile_src;
   logic              r_col_major, w_cm_src;
   logic              r_wr_valid, r_busy, r_done, r_overrun;
   logic [LW-1:0]     r_wr_data, w_lane_data;
   logic [LANES-1:0]  r_wr_strb, w_lane_strb;
   logic              w_capture, w_accept, w_last;
   logic [CW-1:0]     w_l_nxt, w_k_nxt;
   logic [AWIDTH-1:0] w_addr;

   assign w_capture  = (r_state == IDLE) && result_valid;
   assign w_accept   = (r_state == SEND) && r_wr_valid && wr_ready;
   // The first beat is built straight from the inputs so it is valid the cycle after capture.
   assign w_tile_src = w_capture ? result : r_tile;
   assign w_cm_src   = w_capture ? col_major : r_col_major;

   result_drain_addr_gen #(
      .ROWS   (ROWS),
      .COLS   (COLS),
      .AWIDTH (AWIDTH),
      .LANES  (LANES),
      .CW     (CW)
   ) u_addr_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_capture),
      .i_adv       (w_accept),
      .i_col_major (w_cm_src),
      .i_base      (base_addr),
      .i_stride    (row_stride),
      .o_addr      (w_addr),
      .o_l_nxt     (w_l_nxt),
      .o_k_nxt     (w_k_nxt),
      .o_last      (w_last)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (result_valid) w_state_nxt = SEND;
         SEND:    if (w_accept && w_last) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Lane mux for the beat that will be presented after this edge.
   always_comb begin
      int v_ll;
      int v_i;
      int v_e;
      w_lane_data = '0;
      w_lane_strb = '0;
      v_ll = w_cm_src ? ROWS : COLS;
      v_i  = 0;
      v_e  = 0;
      for (int k = 0; k < LANES; k++) begin
         v_i = int'(w_k_nxt) * LANES + k;
         if (v_i < v_ll) begin
            v_e = w_cm_src ? (v_i * COLS + int'(w_l_nxt)) : (int'(w_l_nxt) * COLS + v_i);
            w_lane_data = w_lane_data |
                          (LW'(DWIDTH'(w_tile_src >> ((NE - 1 - v_e) * DWIDTH))) << (k * DWIDTH));
            w_lane_strb = w_lane_strb | (LANES'(1) << k);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tile      <= '0;
         r_col_major <= 1'b0;
         r_wr_valid  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_overrun   <= 1'b0;
         r_wr_data   <= '0;
         r_wr_strb   <= '0;
      end else begin
         r_wr_valid <= (w_state_nxt == SEND);
         r_busy     <= (w_state_nxt == SEND);
         r_done     <= w_accept && w_last;
         r_overrun  <= (r_state == SEND) && result_valid;
         if (w_capture) begin
            r_tile      <= result;
            r_col_major <= col_major;
         end
         if (w_capture || (w_accept && !w_last)) begin
            r_wr_data <= w_lane_data;
            r_wr_strb <= w_lane_strb;
         end else if (w_accept) begin
            r_wr_data <= '0;
            r_wr_strb <= '0;
         end
      end
   end

   assign wr_valid = r_wr_valid;
   assign wr_addr  = w_addr;
   assign wr_data  = r_wr_data;
   assign wr_strb  = r_wr_strb;
   assign busy     = r_busy;
   assign done     = r_done;
   assign overrun  = r_overrun;

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: a LANES=1 and a LANES=3 instance checked against a tile-level beat model.
module tb_result_drain;

   typedef struct {
      logic [15:0] addr;
      logic [47:0] data;
      logic [2:0]  strb;
   } beat_t;

   beat_t got_q[$];
   beat_t exp_q[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n = 1'b0;
   logic [255:0] result = '0;
   logic [15:0]  base_addr = '0, row_stride = '0;
   logic         col_major = 1'b0, wr_ready = 1'b0, rv_pulse = 1'b0, sel = 1'b0;
   logic         rv1, rv3;

   logic        v1, b1, dn1, ov1, v3, b3, dn3, ov3;
   logic [15:0] a1, d1, a3;
   logic [0:0]  s1;
   logic [47:0] d3;
   logic [2:0]  s3;

   logic        m_valid, m_busy, m_done, m_overrun;
   logic [15:0] m_addr;
   logic [47:0] m_data;
   logic [2:0]  m_strb;

   assign rv1 = rv_pulse & ~sel;
   assign rv3 = rv_pulse & sel;

   result_drain #(.ROWS(4), .COLS(4), .DWIDTH(16), .AWIDTH(16), .LANES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .result(result), .result_valid(rv1),
      .base_addr(base_addr), .row_stride(row_stride), .col_major(col_major),
      .wr_valid(v1), .wr_ready(wr_ready), .wr_addr(a1), .wr_data(d1), .wr_strb(s1),
      .busy(b1), .done(dn1), .overrun(ov1));

   result_drain #(.ROWS(4), .COLS(4), .DWIDTH(16), .AWIDTH(16), .LANES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .result(result), .result_valid(rv3),
      .base_addr(base_addr), .row_stride(row_stride), .col_major(col_major),
      .wr_valid(v3), .wr_ready(wr_ready), .wr_addr(a3), .wr_data(d3), .wr_strb(s3),
      .busy(b3), .done(dn3), .overrun(ov3));

   assign m_valid   = sel ? v3 : v1;
   assign m_busy    = sel ? b3 : b1;
   assign m_done    = sel ? dn3 : dn1;
   assign m_overrun = sel ? ov3 : ov1;
   assign m_addr    = sel ? a3 : a1;
   assign m_data    = sel ? d3 : {32'd0, d1};
   assign m_strb    = sel ? s3 : {2'b00, s1};

   int tests = 0, fails = 0;
   int done_cyc, done_cnt, ov_cyc, ov_cnt, stab_err, last_acc;
   logic v_first, b_first, valid_after;
   logic [255:0] st_tile, cap_tile;
   logic [15:0]  st_base, st_stride, cap_base, cap_stride;
   logic         st_cm, cap_cm;

   function automatic logic [255:0] rand_tile();
      logic [255:0] t = '0;
      for (int i = 0; i < 8; i++) t = (t << 32) | 256'($urandom);
      return t;
   endfunction

   function automatic logic [255:0] count_tile();
      logic [255:0] t = '0;
      for (int e = 0; e < 16; e++) t = (t << 16) | 256'(e);
      return t;
   endfunction

   function automatic logic [15:0] elem_of(input logic [255:0] t, input int e);
      return 16'(t >> ((15 - e) * 16));
   endfunction

   // Expected beat list: walk lines and chunks of the stored tile.
   function automatic void build_exp(input logic [255:0] t, input logic [15:0] base,
                                     input logic [15:0] stride, input logic cm, input int lanes);
      int nl, ll, nk, i, r, c;
      beat_t b;
      exp_q.delete();
      nl = cm ? 4 : 4;
      ll = 4;
      nk = (ll + lanes - 1) / lanes;
      for (int L = 0; L < nl; L++) begin
         for (int K = 0; K < nk; K++) begin
            b.addr = 16'(int'(base) + L * int'(stride) + K * lanes);
            b.data = '0;
            b.strb = '0;
            for (int k = 0; k < lanes; k++) begin
               i = K * lanes + k;
               if (i < ll) begin
                  r = cm ? i : L;
                  c = cm ? L : i;
                  b.data = b.data | (48'(elem_of(t, r * 4 + c)) << (k * 16));
                  b.strb = b.strb | 3'(1 << k);
               end
            end
            exp_q.push_back(b);
         end
      end
   endfunction

   function automatic int queue_diff();
      int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data ||
             got_q[i].strb !== exp_q[i].strb) return i;
      if (got_q.size() != exp_q.size()) return n;
      return -1;
   endfunction

   task automatic scramble();
      result     = rand_tile();
      base_addr  = 16'($urandom);
      row_stride = 16'($urandom);
      col_major  = 1'($urandom);
   endtask

   task automatic start(input logic [255:0] t, input logic [15:0] base,
                        input logic [15:0] stride, input logic cm);
      @(negedge clk);
      result = t; base_addr = base; row_stride = stride; col_major = cm;
      st_tile = t; st_base = base; st_stride = stride; st_cm = cm;
      rv_pulse = 1'b1;
   endtask

   // Drives ready, scrambles the mode/address inputs and records accepted beats.
   task automatic collect(input int maxc, input int low_pct, input int inj);
      beat_t pb;
      logic ps = 1'b0, seen = 1'b0;
      got_q.delete();
      done_cyc = -1; done_cnt = 0; ov_cyc = -1; ov_cnt = 0; stab_err = 0; last_acc = -1;
      valid_after = 1'b0;
      for (int cyc = 1; cyc <= maxc; cyc++) begin
         @(negedge clk);
         scramble();
         rv_pulse = (cyc == inj);
         if (cyc == inj) begin
            cap_tile = result; cap_base = base_addr; cap_stride = row_stride; cap_cm = col_major;
         end
         if (cyc == 1) begin v_first = m_valid; b_first = m_busy; end
         if (ps && (!m_valid || m_addr !== pb.addr || m_data !== pb.data || m_strb !== pb.strb))
            stab_err++;
         if (m_overrun) begin ov_cnt++; ov_cyc = cyc; end
         if (m_done) begin
            done_cnt++; done_cyc = cyc; wr_ready = 1'b0; seen = 1'b1;
            break;
         end
         wr_ready = (low_pct == 0) ? 1'b1 : ($urandom_range(99) >= low_pct);
         pb.addr = m_addr; pb.data = m_data; pb.strb = m_strb;
         if (m_valid && wr_ready) begin got_q.push_back(pb); last_acc = cyc; end
         ps = m_valid && !wr_ready;
      end
      if (seen) begin
         @(negedge clk);
         rv_pulse = 1'b0;
         scramble();
         valid_after = m_valid;
         if (m_done) done_cnt++;
         if (m_overrun) ov_cnt++;
      end else begin
         rv_pulse = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sel = 1'b0; wr_ready = 1'b1; rv_pulse = 1'b1;
      repeat (3) begin @(negedge clk); scramble(); end
      tests++;
      if ({v1, b1, dn1, ov1, a1, d1, s1} !== '0) begin
         fails++;
         $display("FAIL reset_dut1: got v=%b b=%b d=%b o=%b addr=%h data=%h strb=%b, exp all 0",
                  v1, b1, dn1, ov1, a1, d1, s1);
      end
      tests++;
      if ({v3, b3, dn3, ov3, a3, d3, s3} !== '0) begin
         fails++;
         $display("FAIL reset_dut3: got v=%b b=%b addr=%h data=%h strb=%b, exp all 0",
                  v3, b3, a3, d3, s3);
      end
      rst_n = 1'b1; rv_pulse = 1'b0;
      @(negedge clk);
      tests++;
      if ({v1, b1, dn1, ov1} !== 4'b0) begin
         fails++;
         $display("FAIL reset_idle: got v=%b b=%b d=%b o=%b, exp 0000", v1, b1, dn1, ov1);
      end
   endtask

   task automatic check_stream(input string name);
      int d = queue_diff();
      tests++;
      if (d != -1) begin
         fails++;
         $display("FAIL %s: first bad beat %0d got addr=%h data=%h strb=%b, exp addr=%h data=%h strb=%b (got %0d beats, exp %0d)",
                  name, d,
                  (d < got_q.size()) ? got_q[d].addr : 16'hxxxx,
                  (d < got_q.size()) ? got_q[d].data : 48'hx,
                  (d < got_q.size()) ? got_q[d].strb : 3'bxxx,
                  (d < exp_q.size()) ? exp_q[d].addr : 16'hxxxx,
                  (d < exp_q.size()) ? exp_q[d].data : 48'hx,
                  (d < exp_q.size()) ? exp_q[d].strb : 3'bxxx,
                  got_q.size(), exp_q.size());
      end
   endtask

   task automatic test_row_major();
      sel = 1'b0;
      start(count_tile(), 16'h0100, 16'd4, 1'b0);
      collect(40, 0, -1);
      build_exp(st_tile, st_base, st_stride, st_cm, 1);
      tests++;
      if (v_first !== 1'b1 || b_first !== 1'b1) begin
         fails++;
         $display("FAIL row_first_cycle: got valid=%b busy=%b, exp 1 1", v_first, b_first);
      end
      check_stream("row_major_stream");
      tests++;
      if (done_cyc != 17 || done_cnt != 1) begin
         fails++;
         $display("FAIL row_done: got cycle %0d count %0d, exp cycle 17 count 1", done_cyc, done_cnt);
      end
      tests++;
      if (got_q.size() != 16 || got_q[15].addr !== 16'h010F || got_q[15].data !== 48'd15) begin
         fails++;
         $display("FAIL row_last_beat: got %0d beats, exp 16 ending addr 010f data 15", got_q.size());
      end
   endtask

   task automatic test_col_major();
      sel = 1'b0;
      start(count_tile(), 16'h0100, 16'd4, 1'b1);
      collect(40, 0, -1);
      build_exp(st_tile, st_base, st_stride, st_cm, 1);
      check_stream("col_major_stream");
      tests++;
      if (got_q.size() < 2 || got_q[1].addr !== 16'h0101 || got_q[1].data !== 48'd4) begin
         fails++;
         $display("FAIL col_second_beat: got %0d beats, exp beat1 addr 0101 data 4", got_q.size());
      end
      tests++;
      if (done_cyc != 17) begin
         fails++;
         $display("FAIL col_done: got cycle %0d, exp 17", done_cyc);
      end
   endtask

   task automatic test_lanes3();
      sel = 1'b1;
      start(count_tile(), 16'h0100, 16'd4, 1'b0);
      collect(40, 0, -1);
      build_exp(st_tile, st_base, st_stride, st_cm, 3);
      check_stream("lanes3_row_stream");
      tests++;
      if (got_q.size() < 2 || got_q[0].strb !== 3'b111 || got_q[0].data !== 48'h0002_0001_0000 ||
          got_q[1].strb !== 3'b001 || got_q[1].data !== 48'd3 || got_q[1].addr !== 16'h0103) begin
         fails++;
         $display("FAIL lanes3_partial: got %0d beats, exp beat0 strb 111 data 000200010000, beat1 strb 001 data 3 addr 0103",
                  got_q.size());
      end
      tests++;
      if (done_cyc != 9) begin
         fails++;
         $display("FAIL lanes3_done: got cycle %0d, exp 9", done_cyc);
      end
      start(rand_tile(), 16'($urandom), 16'($urandom), 1'b1);
      collect(200, 40, -1);
      build_exp(st_tile, st_base, st_stride, st_cm, 3);
      check_stream("lanes3_col_random_stream");
      tests++;
      if (stab_err != 0 || done_cnt != 1 || done_cyc != last_acc + 1) begin
         fails++;
         $display("FAIL lanes3_col_handshake: got stab_err %0d done_cnt %0d done_cyc %0d, exp 0 1 %0d",
                  stab_err, done_cnt, done_cyc, last_acc + 1);
      end
      sel = 1'b0;
   endtask

   task automatic test_random_ready();
      sel = 1'b0;
      for (int n = 0; n < 3; n++) begin
         start(rand_tile(), 16'($urandom), 16'($urandom), 1'($urandom));
         collect(300, 40, -1);
         build_exp(st_tile, st_base, st_stride, st_cm, 1);
         check_stream("random_ready_stream");
         tests++;
         if (stab_err != 0) begin
            fails++;
            $display("FAIL random_ready_stable: got %0d unstable stalled beats, exp 0", stab_err);
         end
         tests++;
         if (done_cnt != 1 || done_cyc != last_acc + 1) begin
            fails++;
            $display("FAIL random_ready_done: got count %0d cycle %0d, exp 1 at cycle %0d",
                     done_cnt, done_cyc, last_acc + 1);
         end
      end
   endtask

   task automatic test_overrun();
      sel = 1'b0;
      start(rand_tile(), 16'($urandom), 16'($urandom), 1'b0);
      collect(40, 0, 5);
      build_exp(st_tile, st_base, st_stride, st_cm, 1);
      tests++;
      if (ov_cnt != 1 || ov_cyc != 6) begin
         fails++;
         $display("FAIL overrun_pulse: got count %0d cycle %0d, exp 1 at 6", ov_cnt, ov_cyc);
      end
      check_stream("overrun_stream");
      tests++;
      if (done_cyc != 17) begin
         fails++;
         $display("FAIL overrun_done: got cycle %0d, exp 17", done_cyc);
      end
   endtask

   task automatic test_back_to_back();
      logic [255:0] t2;
      logic [15:0]  b2, s2;
      logic         c2;
      sel = 1'b0;
      start(rand_tile(), 16'($urandom), 16'($urandom), 1'($urandom));
      collect(40, 0, 17);
      t2 = cap_tile; b2 = cap_base; s2 = cap_stride; c2 = cap_cm;
      build_exp(st_tile, st_base, st_stride, st_cm, 1);
      check_stream("b2b_first_stream");
      tests++;
      if (done_cyc != 17 || done_cnt != 1 || ov_cnt != 0 || valid_after !== 1'b1) begin
         fails++;
         $display("FAIL b2b_restart: got done_cyc %0d done_cnt %0d overruns %0d next_valid %b, exp 17 1 0 1",
                  done_cyc, done_cnt, ov_cnt, valid_after);
      end
      collect(40, 0, -1);
      build_exp(t2, b2, s2, c2, 1);
      check_stream("b2b_second_stream");
      tests++;
      if (done_cnt != 1) begin
         fails++;
         $display("FAIL b2b_second_done: got count %0d, exp 1", done_cnt);
      end
   endtask

   task automatic test_wrap();
      sel = 1'b0;
      start(rand_tile(), 16'hFFFE, 16'd1, 1'b0);
      collect(40, 0, -1);
      build_exp(st_tile, st_base, st_stride, st_cm, 1);
      check_stream("wrap_stream");
      tests++;
      if (got_q.size() < 5 || got_q[2].addr !== 16'h0000 || got_q[4].addr !== 16'hFFFF) begin
         fails++;
         $display("FAIL wrap_addr: got %0d beats, exp beat2 addr 0000 and beat4 addr ffff", got_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int dn = 0;
      sel = 1'b0;
      start(rand_tile(), 16'($urandom), 16'($urandom), 1'($urandom));
      collect(6, 0, -1);
      rst_n = 1'b0;
      @(negedge clk);
      tests++;
      if ({v1, b1, dn1, ov1, a1, d1, s1} !== '0) begin
         fails++;
         $display("FAIL reset_mid_outputs: got v=%b b=%b d=%b addr=%h data=%h strb=%b, exp all 0",
                  v1, b1, dn1, a1, d1, s1);
      end
      @(negedge clk);
      if (dn1) dn++;
      rst_n = 1'b1;
      repeat (2) begin @(negedge clk); if (dn1 || v1) dn++; end
      tests++;
      if (dn != 0) begin
         fails++;
         $display("FAIL reset_mid_quiet: got %0d cycles with done/valid after abort, exp 0", dn);
      end
      start(rand_tile(), 16'($urandom), 16'($urandom), 1'($urandom));
      collect(40, 0, -1);
      build_exp(st_tile, st_base, st_stride, st_cm, 1);
      check_stream("reset_mid_fresh_stream");
      tests++;
      if (done_cnt != 1 || done_cyc != 17) begin
         fails++;
         $display("FAIL reset_mid_fresh_done: got count %0d cycle %0d, exp 1 at 17", done_cnt, done_cyc);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_row_major();
      test_col_major();
      test_lanes3();
      test_random_ready();
      test_overrun();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/result_drain.md
# result_drain

Parametrised drain engine that takes a completed systolic-array result tile and streams it to the result SRAM/bus as addressed write beats. It sits between the systolic array (`finish_systolic`-style completion pulse plus flat result vector) and the memory write port. It generalises the single-word serial unload to configurable tile size and lanes per beat. It adds ready/valid backpressure, base/stride addressing, an optional transposed (column-major) store, partial-beat strobes and overrun reporting.

## Interface
Parameters:
- `ROWS`, 4: PE rows in the tile.
- `COLS`, 4: PE columns in the tile.
- `DWIDTH`, 16: bits per element.
- `AWIDTH`, 16: address width, in element units.
- `LANES`, 1: elements per write beat, 1..max(ROWS,COLS).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `result` in ROWS*COLS*DWIDTH: tile. Element e = r*COLS+c sits at bits [(ROWS*COLS-1-e)*DWIDTH +: DWIDTH], so element 0 is in the MSBs.
- `result_valid` in 1: one-cycle tile-complete pulse.
- `base_addr` in AWIDTH: destination of element (0,0). Sampled at capture.
- `row_stride` in AWIDTH: address distance between stored lines. Sampled at capture.
- `col_major` in 1: 0 = row-major store, 1 = transposed store. Sampled at capture.
- `wr_valid` out 1: beat valid.
- `wr_ready` in 1: sink accepts beat.
- `wr_addr` out AWIDTH: address of lane 0.
- `wr_data` out LANES*DWIDTH: lane k at bits [k*DWIDTH +: DWIDTH].
- `wr_strb` out LANES: lane-enable mask.
- `busy` out 1: tile captured and not fully drained.
- `done` out 1: one-cycle pulse after the last beat is accepted.
- `overrun` out 1: one-cycle pulse when `result_valid` is dropped.

## Operation
- States: IDLE and SEND.
- IDLE:
  - `result_valid`=1 latches `result`, `base_addr`, `row_stride` and `col_major` into shadow registers.
  - Clears the line counter L and chunk counter K, then moves to SEND.
- Line and chunk geometry:
  - Row-major: a line is a row. NL=ROWS lines, line length LL=COLS.
  - Col-major: a line is a column. NL=COLS lines, LL=ROWS.
  - Chunks per line NK = ceil(LL/LANES). Beats per tile = NL*NK.
- SEND, beat (L,K):
  - Lane k carries line element i = K*LANES+k.
  - Element (r,c) is (L,i) in row-major and (i,L) in col-major.
  - `wr_addr` = base + L*row_stride + K*LANES, truncated mod 2^AWIDTH. Wrap-around is legal and silent.
  - `wr_strb[k]` = (i < LL). Lanes with i >= LL drive data 0.
- Handshake advance:
  - Beat is accepted when `wr_valid`&&`wr_ready`.
  - On accept, K increments. At K=NK-1, K returns to 0 and L increments.
  - Accepting beat (NL-1,NK-1) returns the block to IDLE and sets `done`.
- While not accepted, `wr_addr`/`wr_data`/`wr_strb` stay stable (AXI-style). `wr_valid` never drops before accept.
- `result_valid` while in SEND: ignored, tile not captured, shadow state unchanged, `overrun`=1 next cycle.
- `result_valid` in the cycle `done` is high: the block is already in IDLE, so the tile is captured normally.
- Reset mid-transfer: transfer aborted, no `done`, all outputs return to reset values.
- Mode and addressing inputs are ignored outside the capture cycle.

## Timing
- Reset values: `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `wr_strb`=0, `busy`=0, `done`=0, `overrun`=0. Shadow registers and counters are cleared.
- Capture at edge N (result_valid=1). `wr_valid`=1 and `busy`=1 from cycle N+1.
- With `wr_ready` held at 1: one beat per cycle, the last beat in cycle N+NL*NK, `done`=1 and `busy`=0 in cycle N+NL*NK+1.
- Each cycle with `wr_ready`=0 adds one cycle of latency.
- All outputs are registered. There is no combinational path from `wr_ready` or `result_valid` to any output.

## Structure
- Package `result_drain_pkg`:
  - `rd_state_t` enum {IDLE, SEND}.
  - Function `ceil_div(a,b)`.
  - Localparams NL/NK computation helpers for both modes.
- Sub-module `result_drain_addr_gen`: holds the L/K counters, last-beat flag and address accumulator (base + L*stride via a running add, no multiplier). Advanced by an accept strobe.
- The top handles capture, the lane mux from the shadow tile, strobes, the FSM and pulses.

## Test plan
- ROWS=COLS=4, LANES=1, element e = e, base=0x100, stride=4, row-major, ready=1:
  - 16 beats at addr 0x100..0x10F carrying data 0..15.
  - `done` exactly 17 cycles after capture.
- Same tile with col_major=1: beats in order data 0,4,8,12,1,5,…; addr 0x100+c*4+r.
- LANES=3, COLS=4, row-major: 8 beats.
  - Per row: strb 3'b111 at offset 0, then 3'b001 at offset 3 carrying element 3.
  - Unused lanes are 0.
- Random `wr_ready` (~40% low):
  - Payload stable while valid&&!ready.
  - Beat sequence identical to the ready=1 run.
  - `done` only after the last accept.
- `result_valid` mid-SEND: `overrun` pulse next cycle, output stream unchanged.
- `result_valid` coincident with `done`: a second tile starts the next cycle.
- base=0xFFFE, stride=1: addresses 0xFFFE, 0xFFFF, 0x0000, …, wrapping mod 2^16.
- Reset asserted mid-SEND: outputs go to 0 next cycle, no `done`, and a fresh capture afterwards drains correctly.
